xmem_arbiter: RTL and testbench

Two-master round-robin Wishbone arbiter sharing the single HyperRAM external-memory port (xmem) between the service processor and a second bus master, such as a future tape/disk DMA engine. It sits between the masters and `hyperram_wrapper`, muxing one granted master onto the slave port for the whole duration of its `cyc`. An optional watchdog aborts cycles the memory never acknowledges.

---
 rtl/xmem_arbiter.sv | 130 +++++++++++++
 tb/tb_xmem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xmem_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the HyperRAM port.
// Define XMEM_ARB_TIMEOUT_EN to build in the unacknowledged-cycle watchdog.
module xmem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:31] m0_adr_i,
  input  logic [0:31] m0_dat_i,
  output logic [0:31] m0_dat_o,
  input  logic        m0_we_i,
  input  logic [0:3]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [2:31] m1_adr_i,
  input  logic [0:31] m1_dat_i,
  output logic [0:31] m1_dat_o,
  input  logic        m1_we_i,
  input  logic [0:3]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [2:31] s_adr_o,
  output logic [0:31] s_dat_o,
  output logic        s_we_o,
  output logic [0:3]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [0:31] s_dat_i,
  input  logic        s_ack_i,
  output logic [0:1]  owner
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("xmem_arbiter: TIMEOUT_CYCLES out of range 2..65535");
  end

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

  state_t state;
  logic   last;
  logic   busy;
  logic   sel1;
  logic   own_cyc;
  logic   timeout;

  assign busy    = (state == OWN0) || (state == OWN1);
  assign sel1    = (state == OWN1);
  assign own_cyc = owner[1] ? m1_cyc_i : m0_cyc_i;

  // Non-strobe slave fields mirror m0 whenever m1 is not the owner.
  assign s_adr_o = sel1 ? m1_adr_i : m0_adr_i;
  assign s_dat_o = sel1 ? m1_dat_i : m0_dat_i;
  assign s_we_o  = sel1 ? m1_we_i  : m0_we_i;
  assign s_sel_o = sel1 ? m1_sel_i : m0_sel_i;
  assign s_cyc_o = busy && (sel1 ? m1_cyc_i : m0_cyc_i);
  assign s_stb_o = busy && (sel1 ? m1_stb_i : m0_stb_i);

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = !reset && (state == OWN0) && s_ack_i && !timeout;
  assign m1_ack_o = !reset && (state == OWN1) && s_ack_i && !timeout;

`ifdef XMEM_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        own_stb;

  assign own_stb = owner[1] ? m1_stb_i : m0_stb_i;
  assign timeout = busy && (wd_cnt == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset || !busy || !own_stb || s_ack_i || timeout)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 16'd1;
  end

  assign m0_err_o = !reset && (state == OWN0) && timeout;
  assign m1_err_o = !reset && (state == OWN1) && timeout;
`else
  assign timeout  = 1'b0;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 2'b00;
      last  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          // On contention the master not served last wins.
          if (m0_cyc_i && (!m1_cyc_i || last)) begin
            state <= OWN0;
            owner <= 2'b10;
          end else if (m1_cyc_i) begin
            state <= OWN1;
            owner <= 2'b01;
          end
        end
        OWN0, OWN1: begin
          if (timeout) begin
            state <= ABORT;
          end else if (!own_cyc) begin
            state <= IDLE;
            owner <= 2'b00;
            last  <= owner[1];
          end
        end
        ABORT: begin
          if (!own_cyc) begin
            state <= IDLE;
            owner <= 2'b00;
            last  <= owner[1];
          end
        end
        default: begin
          state <= IDLE;
          owner <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xmem_arbiter.sv
// Directed plus randomized bench for xmem_arbiter against a cycle-level
// model of the grant rules; the watchdog part follows XMEM_ARB_TIMEOUT_EN.
module tb_xmem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:31] adr [2];
  logic [0:31] wdat [2];
  logic [0:31] rdat [2];
  logic        we [2];
  logic [0:3]  sel [2];
  logic        stb [2];
  logic        cyc [2];
  logic        ack [2];
  logic        err [2];
  logic [2:31] s_adr;
  logic [0:31] s_dat_o;
  logic [0:31] s_dat_i;
  logic        s_we;
  logic [0:3]  s_sel;
  logic        s_stb;
  logic        s_cyc;
  logic        s_ack;
  logic [0:1]  owner;

  always #5 clk = ~clk;

  xmem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(rdat[0]),
    .m0_we_i(we[0]), .m0_sel_i(sel[0]), .m0_stb_i(stb[0]),
    .m0_cyc_i(cyc[0]), .m0_ack_o(ack[0]), .m0_err_o(err[0]),
    .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(rdat[1]),
    .m1_we_i(we[1]), .m1_sel_i(sel[1]), .m1_stb_i(stb[1]),
    .m1_cyc_i(cyc[1]), .m1_ack_o(ack[1]), .m1_err_o(err[1]),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_we_o(s_we),
    .s_sel_o(s_sel), .s_stb_o(s_stb), .s_cyc_o(s_cyc),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .owner(owner)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: who holds the bus, whether it is aborted, who went last.
  int own  = -1;
  bit ab   = 1'b0;
  int last = 1;
  int wait_cnt = 0;
  bit exp_ack [2];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_m(input int i, input bit c, input bit s, input bit w,
                       input logic [2:31] a, input logic [0:31] d,
                       input logic [0:3] sl);
    cyc[i]  = c;
    stb[i]  = s;
    we[i]   = w;
    adr[i]  = a;
    wdat[i] = d;
    sel[i]  = sl;
  endtask

  // Check every output against the model, then cross one clock edge.
  task automatic step();
    bit act, t;
    int m;
    logic [0:1] eo;
    #1;
    act = (own >= 0) && !ab;
    m   = (act && own == 1) ? 1 : 0;
`ifdef XMEM_ARB_TIMEOUT_EN
    t = act && (wait_cnt == TO);
`else
    t = 1'b0;
`endif
    eo = (own == 0) ? 2'b10 : (own == 1) ? 2'b01 : 2'b00;
    chk("owner", 64'(owner), 64'(eo));
    chk("s_cyc", 64'(s_cyc), 64'(act && cyc[m]));
    chk("s_stb", 64'(s_stb), 64'(act && stb[m]));
    chk("s_adr", 64'(s_adr), 64'(adr[m]));
    chk("s_dat", 64'(s_dat_o), 64'(wdat[m]));
    chk("s_we", 64'(s_we), 64'(we[m]));
    chk("s_sel", 64'(s_sel), 64'(sel[m]));
    for (int i = 0; i < 2; i++) begin
      exp_ack[i] = !reset && act && own == i && s_ack && !t;
      chk($sformatf("ack%0d", i), 64'(ack[i]), 64'(exp_ack[i]));
      chk($sformatf("err%0d", i), 64'(err[i]),
          64'(!reset && act && own == i && t));
      chk($sformatf("rdat%0d", i), 64'(rdat[i]), 64'(s_dat_i));
    end
    @(posedge clk);
    if (reset) begin
      own = -1; ab = 1'b0; last = 1; wait_cnt = 0;
    end else begin
      int nc;
      nc = (act && stb[m] && !s_ack) ? wait_cnt + 1 : 0;
      if (own < 0) begin
        if (cyc[0] && cyc[1]) own = 1 - last;
        else if (cyc[0]) own = 0;
        else if (cyc[1]) own = 1;
      end else if (ab || !t) begin
        if (!cyc[own]) begin
          last = own; own = -1; ab = 1'b0;
        end
      end else begin
        ab = 1'b1; nc = 0;
      end
      wait_cnt = nc;
    end
    #1;
  endtask

  task automatic idle_all();
    set_m(0, 0, 0, 0, '0, '0, '0);
    set_m(1, 0, 0, 0, '0, '0, '0);
    s_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  int rem [2];
  int k;
  int gap;

  initial begin
    s_dat_i = '0;
    do_reset();
    #1 chk("rst_owner", 64'(owner), 64'(2'b00));
    chk("rst_s_cyc", 64'(s_cyc), 64'(0));

    // Single master write then read back.
    set_m(0, 1, 1, 1, 30'h100, 32'hDEADBEEF, 4'b1111);
    step();
    chk("t1_owner", 64'(owner), 64'(2'b10));
    chk("t1_adr", 64'(s_adr), 64'(30'h100));
    chk("t1_dat", 64'(s_dat_o), 64'(32'hDEADBEEF));
    s_ack = 1'b1;
    #1 chk("t1_wack", 64'(ack[0]), 64'(1));
    step();
    set_m(0, 1, 1, 0, 30'h100, '0, 4'b1111);
    s_dat_i = 32'hDEADBEEF;
    #1 chk("t1_rdat", 64'(rdat[0]), 64'(32'hDEADBEEF));
    chk("t1_m1ack", 64'(ack[1]), 64'(0));
    step();
    idle_all();
    #1 chk("t1_drop_cyc", 64'(s_cyc), 64'(0));
    step();
    chk("t1_owner_idle", 64'(owner), 64'(2'b00));

    // Contention straight after reset: m0 first, then m1, then m0 again.
    do_reset();
    set_m(0, 1, 1, 1, 30'h10, 32'h1111_0000, 4'b1100);
    set_m(1, 1, 1, 1, 30'h20, 32'h2222_0000, 4'b0011);
    step();
    chk("c_first", 64'(owner), 64'(2'b10));
    s_ack = 1'b1;
    repeat (3) step();
    set_m(0, 0, 0, 0, '0, '0, '0);
    step();
    chk("c_bubble", 64'(owner), 64'(2'b00));
    step();
    chk("c_second", 64'(owner), 64'(2'b01));
    repeat (3) step();
    set_m(1, 0, 0, 0, '0, '0, '0);
    step();
    set_m(0, 1, 1, 0, 30'h30, '0, 4'b1111);
    set_m(1, 1, 1, 0, 30'h40, '0, 4'b1111);
    step();
    chk("c_third", 64'(owner), 64'(2'b10));
    idle_all();
    step();
    step();

    // Randomized traffic with a slave that never stalls past three cycles.
    rem[0] = 0;
    rem[1] = 0;
    gap = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (rem[i] == 0 && $urandom_range(3) == 0) begin
          rem[i] = $urandom_range(1, 4);
          set_m(i, 1, 1, 1'($urandom), 30'($urandom), $urandom,
                4'($urandom));
        end
      end
      s_ack   = (gap >= 3) || ($urandom_range(1) == 1);
      gap     = s_ack ? 0 : gap + 1;
      s_dat_i = $urandom;
      step();
      for (int i = 0; i < 2; i++) begin
        if (exp_ack[i]) begin
          rem[i]--;
          if (rem[i] == 0)
            set_m(i, 0, 0, 0, '0, '0, '0);
          else
            set_m(i, 1, 1, 1'($urandom), 30'($urandom), $urandom,
                  4'($urandom));
        end
      end
    end
    idle_all();
    step();
    step();
    step();

    // Long m1 burst: m0 waits until m1 lets go.
    set_m(1, 1, 1, 1, 30'h55, 32'hCAFE0000, 4'b1111);
    step();
    set_m(0, 1, 1, 0, 30'h66, '0, 4'b1111);
    s_ack = 1'b1;
    for (int n = 0; n < 20; n++) begin
      chk("lb_hold", 64'(owner), 64'(2'b01));
      step();
    end
    set_m(1, 0, 0, 0, '0, '0, '0);
    step();
    chk("lb_bubble", 64'(owner), 64'(2'b00));
    step();
    chk("lb_m0", 64'(owner), 64'(2'b10));
    idle_all();
    step();
    step();

    // Reset while m1 has an unacknowledged strobe.
    set_m(1, 1, 1, 0, 30'h77, '0, 4'b1111);
    step();
    chk("rm_own", 64'(owner), 64'(2'b01));
    reset = 1'b1;
    s_ack = 1'b1;
    #1 chk("rm_noack", 64'(ack[1]), 64'(0));
    step();
    reset = 1'b0;
    chk("rm_s_cyc", 64'(s_cyc), 64'(0));
    chk("rm_owner", 64'(owner), 64'(2'b00));
    chk("rm_late_ack", 64'(ack[1]), 64'(0));
    step();
    idle_all();
    step();
    step();

    // Memory never answers m0.
    do_reset();
    set_m(0, 1, 1, 0, 30'h88, '0, 4'b1111);
    step();
`ifdef XMEM_ARB_TIMEOUT_EN
    for (k = 0; k < 20; k++) begin
      #1;
      if (err[0] === 1'b1) break;
      step();
    end
    chk("wd_delay", 64'(k), 64'(TO));
    step();
    chk("wd_s_cyc", 64'(s_cyc), 64'(0));
    set_m(1, 1, 1, 1, 30'h99, 32'h0BADF00D, 4'b1111);
    step();
    step();
    set_m(0, 0, 0, 0, '0, '0, '0);
    step();
    chk("wd_bubble", 64'(owner), 64'(2'b00));
    step();
    chk("wd_m1", 64'(owner), 64'(2'b01));
`else
    for (int n = 0; n < 1000; n++) begin
      chk("stall_stb", 64'(s_stb), 64'(1));
      step();
    end
`endif
    idle_all();
    step();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
